// File: rtl/ps2_kbd_tx_if.sv
// Byte-stream handshake into the PS/2 keyboard transmitter.
// A byte transfers on a clock edge where in_valid and in_ready are both high.
interface ps2_kbd_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: FIFO-buffered scan-code bytes sent as 11-bit frames.
// Optional macro PS2_TX_ERR_INJECT_EN adds err_inject, which inverts a frame's parity bit.
module ps2_kbd_tx #(
    parameter int CLK_DIV  = 50,
    parameter int FIFO_AW  = 3,
    parameter int GAP_HALF = 4
) (
    input  logic               clk,
    input  logic               resetn,
`ifdef PS2_TX_ERR_INJECT_EN
    input  logic               err_inject,
`endif
    ps2_kbd_tx_if.slave        in_bus,
    output logic               ps2_clk,
    output logic               ps2_data,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int GAP_CYC = GAP_HALF * CLK_DIV;
    localparam int CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [3:0]         bit_cnt, bit_cnt_d;
    logic [9:0]         shift, shift_d;
    logic               ps2_clk_d, ps2_data_d;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               push, pop;
    logic [7:0]         head;
    logic               parity;

    assign in_bus.in_ready = (fifo_count != FULL_COUNT);
    assign push            = in_bus.in_valid && in_bus.in_ready;
    assign head            = mem[rd_ptr];

`ifdef PS2_TX_ERR_INJECT_EN
    assign parity = (~^head) ^ err_inject;
`else
    assign parity = ~^head;
`endif

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        ps2_clk_d  = ps2_clk;
        ps2_data_d = ps2_data;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shift_d    = {1'b1, parity, head};
                    ps2_data_d = 1'b0;
                    bit_cnt_d  = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt == HALF_LAST) begin
                    cnt_d = '0;
                    if (ps2_clk) begin
                        ps2_clk_d = 1'b0;
                    end else begin
                        // Rising edge: the next bit goes out a full half-period ahead of its falling edge.
                        ps2_clk_d = 1'b1;
                        if (bit_cnt == 4'd10) begin
                            state_d = GAP;
                        end else begin
                            ps2_data_d = shift[0];
                            shift_d    = {1'b0, shift[9:1]};
                            bit_cnt_d  = bit_cnt + 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            GAP: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            ps2_clk  <= ps2_clk_d;
            ps2_data <= ps2_data_d;
            busy     <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + COUNT_ONE;
                2'b01:   fifo_count <= fifo_count - COUNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the zeroed pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_bus.in_data;
    end

endmodule
